// File: rtl/db_top_rd_ctrl_if.sv
// RAM read port plus the outbound row stream of the deblocking top-pixel read controller.
// Stream handshake: a beat transfers on a rising clk edge where valid_o && ready_i; once valid_o is
// raised the beat (data_o/row_o/last_o) holds until accepted, and ready_i may toggle freely.
interface db_top_rd_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
);
  logic                  cen_o;
  logic                  ren_o;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [ADDR_WIDTH-1:0] row_o;
  logic                  last_o;

  modport master (
    output cen_o, ren_o, wen_o, addr_o, valid_o, data_o, row_o, last_o,
    input  ram_data_i, ready_i
  );

  modport slave (
    input  cen_o, ren_o, wen_o, addr_o, valid_o, data_o, row_o, last_o,
    output ram_data_i, ready_i
  );
endinterface

// File: rtl/db_top_rd_ctrl.sv
// Reads Y (and optionally Cb/Cr) rows from the top-pixel RAM and streams them out through
// a 2-entry buffer that hides the 1-cycle RAM latency from downstream backpressure.
module db_top_rd_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int Y_ROWS     = 16,
  parameter int C_ROWS     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        chroma_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  dbg_state_o,
  db_top_rd_ctrl_if.master bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LEN_Y  = CW'(Y_ROWS);
  localparam logic [CW-1:0] LEN_YC = CW'(Y_ROWS + C_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  chroma_q;
  logic [CW-1:0]         issue_cnt_q;
  logic [CW-1:0]         pass_len;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_row_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [ADDR_WIDTH-1:0] fifo_row_q  [2];
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic       push, pop, issue, last_issue, push_last, valid;
  logic [2:0] occ;

  assign pass_len = chroma_q ? LEN_YC : LEN_Y;
  assign valid    = (fifo_cnt_q != 2'd0);
  assign pop      = valid && bus.ready_i;
  assign push     = inflight_q;

  // Credit counts the beat leaving this cycle, so a full-rate stream keeps one read per cycle
  // while a stalled stream stops issuing once buffer plus in-flight read reach two.
  assign occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_READ) && (occ < 3'd2);
  assign last_issue = issue && (issue_cnt_q == pass_len - CW'(1));
  assign push_last  = ({1'b0, inflight_row_q} == pass_len - CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_READ;
      ST_READ:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && bus.last_o) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      chroma_q       <= 1'b0;
      issue_cnt_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_row_q <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_row_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && start_i) begin
        chroma_q    <= chroma_en_i;
        issue_cnt_q <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + CW'(1);
      end

      inflight_q <= issue;
      if (issue) inflight_row_q <= issue_cnt_q[ADDR_WIDTH-1:0];

      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.ram_data_i;
        fifo_row_q[wr_ptr_q]  <= inflight_row_q;
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ren_o stays low across the whole pass so the returning word is always driven.
  assign busy_o      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

  assign bus.cen_o   = ~issue;
  assign bus.ren_o   = ~busy_o;
  assign bus.wen_o   = 1'b1;
  assign bus.addr_o  = issue ? issue_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign bus.valid_o = valid;
  assign bus.data_o  = fifo_data_q[rd_ptr_q];
  assign bus.row_o   = fifo_row_q[rd_ptr_q];
  assign bus.last_o  = valid && fifo_last_q[rd_ptr_q];

endmodule
